// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates ICache/DCache refills and DCache write-backs onto one AXI-like memory bus.
// Ports: clk/rstn (sync active-low); i_rreq/i_raddr, d_rreq/d_raddr refill requests;
// d_wreq/d_waddr/d_wline write-back request; i_ret_*/d_ret_*/ret_data return beats; d_wdone write-back done;
// mem_ar*/mem_r* read channels; mem_aw*/mem_w*/mem_b* write channels.
module mem_bus_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_rreq,
  input  logic [31:0]             i_raddr,
  input  logic                    d_rreq,
  input  logic [31:0]             d_raddr,
  input  logic                    d_wreq,
  input  logic [31:0]             d_waddr,
  input  logic [32*BURST_LEN-1:0] d_wline,
  output logic                    i_ret_valid,
  output logic                    i_ret_last,
  output logic                    d_ret_valid,
  output logic                    d_ret_last,
  output logic [31:0]             ret_data,
  output logic                    d_wdone,
  output logic                    mem_arvalid,
  output logic [31:0]             mem_araddr,
  output logic [7:0]              mem_arlen,
  input  logic                    mem_arready,
  input  logic                    mem_rvalid,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_rlast,
  output logic                    mem_rready,
  output logic                    mem_awvalid,
  output logic [31:0]             mem_awaddr,
  output logic [7:0]              mem_awlen,
  input  logic                    mem_awready,
  output logic                    mem_wvalid,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_wstrb,
  output logic                    mem_wlast,
  input  logic                    mem_wready,
  input  logic                    mem_bvalid,
  output logic                    mem_bready
);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;
  state_t state, state_nxt;
  logic is_d, is_d_nxt, last_rd, last_rd_nxt, pick_d, beat;
  logic [31:0] addr, addr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // last_rd=1 means the previous read served D, so I wins the next tie; reset value 0 favours D
  assign pick_d = d_rreq & (~i_rreq | ~last_rd);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      is_d    <= 1'b0;
      addr    <= '0;
      cnt     <= '0;
      last_rd <= 1'b0;
    end else begin
      state   <= state_nxt;
      is_d    <= is_d_nxt;
      addr    <= addr_nxt;
      cnt     <= cnt_nxt;
      last_rd <= last_rd_nxt;
    end
  end
  always_comb begin
    state_nxt   = state;
    is_d_nxt    = is_d;
    addr_nxt    = addr;
    cnt_nxt     = cnt;
    last_rd_nxt = last_rd;
    case (state)
      IDLE: begin
        if (d_wreq) begin
          state_nxt = AW;
          is_d_nxt  = 1'b1;
          addr_nxt  = d_waddr;
        end else if (d_rreq | i_rreq) begin
          state_nxt = AR;
          is_d_nxt  = pick_d;
          addr_nxt  = pick_d ? d_raddr : i_raddr;
        end
      end
      AR: state_nxt = mem_arready ? R : AR;
      R: begin
        if (mem_rvalid & mem_rlast) begin
          state_nxt   = IDLE;
          last_rd_nxt = is_d;
        end
      end
      AW: begin
        if (mem_awready) begin
          state_nxt = W;
          cnt_nxt   = '0;
        end
      end
      W: begin
        if (mem_wready) begin
          state_nxt = (cnt == LAST) ? B : W;
          cnt_nxt   = (cnt == LAST) ? cnt : cnt + 1'b1;
        end
      end
      B: state_nxt = mem_bvalid ? IDLE : B;
      default: state_nxt = IDLE;
    endcase
  end
  assign beat        = (state == R) & mem_rvalid;
  assign mem_arvalid = state == AR;
  assign mem_araddr  = mem_arvalid ? addr : '0;
  assign mem_arlen   = mem_arvalid ? 8'(BURST_LEN - 1) : '0;
  assign mem_rready  = state == R;
  assign i_ret_valid = beat & ~is_d;
  assign d_ret_valid = beat & is_d;
  assign i_ret_last  = i_ret_valid & mem_rlast;
  assign d_ret_last  = d_ret_valid & mem_rlast;
  assign ret_data    = beat ? mem_rdata : '0;
  assign mem_awvalid = state == AW;
  assign mem_awaddr  = mem_awvalid ? addr : '0;
  assign mem_awlen   = mem_awvalid ? 8'(BURST_LEN - 1) : '0;
  assign mem_wvalid  = state == W;
  assign mem_wdata   = mem_wvalid ? d_wline[{cnt, 5'd0} +: 32] : '0;
  assign mem_wstrb   = mem_wvalid ? 4'hF : 4'h0;
  assign mem_wlast   = mem_wvalid & (cnt == LAST);
  assign mem_bready  = state == B;
  assign d_wdone     = mem_bready & mem_bvalid;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter with BURST_LEN=4.
module tb_mem_bus_arbiter;
  logic clk = 1'b0, rstn = 1'b0;
  logic i_rreq = 0, d_rreq = 0, d_wreq = 0;
  logic [31:0] i_raddr = 0, d_raddr = 0, d_waddr = 0;
  logic [127:0] d_wline = 0;
  logic i_ret_valid, i_ret_last, d_ret_valid, d_ret_last, d_wdone;
  logic [31:0] ret_data, mem_araddr, mem_awaddr, mem_wdata;
  logic [7:0] mem_arlen, mem_awlen;
  logic [3:0] mem_wstrb;
  logic mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_wlast, mem_bready;
  logic mem_arready = 0, mem_rvalid = 0, mem_rlast = 0, mem_awready = 0, mem_wready = 0, mem_bvalid = 0;
  logic [31:0] mem_rdata = 0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mem_bus_arbiter #(.BURST_LEN(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_rreq(i_rreq), .i_raddr(i_raddr), .d_rreq(d_rreq), .d_raddr(d_raddr),
    .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wline(d_wline),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
    .ret_data(ret_data), .d_wdone(d_wdone),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .mem_rready(mem_rready),
    .mem_awvalid(mem_awvalid), .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen), .mem_awready(mem_awready),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
    .mem_wready(mem_wready), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_arv"}, mem_arvalid, 0);
    chk({tag, "_araddr"}, mem_araddr, 0);
    chk({tag, "_rrdy"}, mem_rready, 0);
    chk({tag, "_awv"}, mem_awvalid, 0);
    chk({tag, "_wv"}, mem_wvalid, 0);
    chk({tag, "_brdy"}, mem_bready, 0);
    chk({tag, "_iret"}, i_ret_valid, 0);
    chk({tag, "_dret"}, d_ret_valid, 0);
    chk({tag, "_wdone"}, d_wdone, 0);
  endtask
  task automatic reset_dut;
    rstn = 0;
    {i_rreq, d_rreq, d_wreq, mem_arready, mem_rvalid, mem_rlast, mem_awready, mem_wready, mem_bvalid} = '0;
    repeat (2) step;
    chk_quiet("rst");
    rstn = 1;
  endtask
  // entered with the DUT in AR; returns one cycle after the last beat edge (DUT back in IDLE)
  task automatic do_read(input logic is_d, input logic [31:0] addr, input logic [31:0] base, input int ar_wait);
    for (int w = 0; w < ar_wait; w++) begin
      #1;
      chk("ar_hold_v", mem_arvalid, 1);
      chk("ar_hold_addr", mem_araddr, addr);
      step;
    end
    mem_arready = 1;
    #1;
    chk("arv", mem_arvalid, 1);
    chk("araddr", mem_araddr, addr);
    chk("arlen", mem_arlen, 3);
    chk("ar_rrdy", mem_rready, 0);
    step;
    mem_arready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        mem_rvalid = 0;
        #1;
        chk("gap_iret", i_ret_valid, 0);
        chk("gap_dret", d_ret_valid, 0);
        chk("gap_arv", mem_arvalid, 0);
        step;
      end
      mem_rvalid = 1;
      mem_rdata = base + k;
      mem_rlast = (k == 3);
      #1;
      chk("rrdy", mem_rready, 1);
      chk("iret", i_ret_valid, !is_d);
      chk("dret", d_ret_valid, is_d);
      chk("ilast", i_ret_last, !is_d && k == 3);
      chk("dlast", d_ret_last, is_d && k == 3);
      chk("rdata", ret_data, base + k);
      step;
    end
    mem_rvalid = 0;
    mem_rlast = 0;
  endtask
  initial begin
    reset_dut;
    i_rreq = 1;
    i_raddr = 32'h1C00_0000;
    step;
    do_read(0, 32'h1C00_0000, 32'hA0, 0);
    i_rreq = 0;
    #1;
    chk_quiet("t1_idle");
    step;
    chk("t1_no_regrant", mem_arvalid, 0);
    reset_dut;
    i_rreq = 1;
    d_rreq = 1;
    i_raddr = 32'h0000_1000;
    d_raddr = 32'h0000_2000;
    step;
    do_read(1, 32'h0000_2000, 32'hD0, 2);
    step;
    do_read(0, 32'h0000_1000, 32'hC0, 0);
    step;
    do_read(1, 32'h0000_2000, 32'hE0, 1);
    i_rreq = 0;
    d_rreq = 0;
    reset_dut;
    d_wreq = 1;
    d_rreq = 1;
    i_rreq = 1;
    d_waddr = 32'h0000_8000;
    d_raddr = 32'h0000_4000;
    i_raddr = 32'h0000_5000;
    d_wline = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    step;
    chk("awv", mem_awvalid, 1);
    chk("awaddr", mem_awaddr, 32'h0000_8000);
    chk("awlen", mem_awlen, 3);
    chk("aw_arv", mem_arvalid, 0);
    mem_awready = 1;
    step;
    mem_awready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        mem_wready = 0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_wv", mem_wvalid, 1);
          chk("stall_wdata", mem_wdata, 32'h3333_0002);
          chk("stall_wlast", mem_wlast, 0);
          step;
        end
      end
      mem_wready = 1;
      #1;
      chk("wv", mem_wvalid, 1);
      chk("wstrb", mem_wstrb, 4'hF);
      chk("wdata", mem_wdata, d_wline[k*32 +: 32]);
      chk("wlast", mem_wlast, k == 3);
      step;
    end
    mem_wready = 0;
    #1;
    chk("b_rdy", mem_bready, 1);
    chk("b_wv", mem_wvalid, 0);
    chk("b_wdone_early", d_wdone, 0);
    step;
    mem_bvalid = 1;
    #1;
    chk("wdone", d_wdone, 1);
    step;
    mem_bvalid = 0;
    d_wreq = 0;
    #1;
    chk("wdone_pulse", d_wdone, 0);
    chk("b_exit", mem_bready, 0);
    step;
    do_read(1, 32'h0000_4000, 32'hF0, 0);
    d_rreq = 0;
    i_rreq = 0;
    reset_dut;
    i_rreq = 1;
    i_raddr = 32'h0000_3000;
    step;
    mem_arready = 1;
    step;
    mem_arready = 0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1;
      mem_rdata = 32'h90 + k;
      #1;
      chk("pre_rst_iret", i_ret_valid, 1);
      step;
    end
    rstn = 0;
    mem_rdata = 32'hEE;
    step;
    chk_quiet("mid_rst");
    chk("mid_rst_data", ret_data, 0);
    rstn = 1;
    mem_rvalid = 0;
    step;
    do_read(0, 32'h0000_3000, 32'hB0, 0);
    i_rreq = 0;
    step;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
